// File: rtl/imem_arb_pkg.sv
// Shared types, constants and the byte-address check for the instruction-memory fetch arbiter.
package imem_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 10;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned BYTE_ADDR_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } grant_e;

    // Misaligned, or any bit set above the addressable word range.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'h0);
    endfunction

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
interface imem_fetch_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_err;

    logic              load_req;
    logic [31:0]       load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_err;
    logic              load_done;
    logic              reload;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              booted;

    // Arbiter side.
    modport slave (
        input  fetch_req, fetch_addr, load_req, load_addr, load_data,
               load_done, reload, mem_rdata,
        output fetch_ready, fetch_valid, fetch_instr, fetch_err,
               load_ready, load_err, mem_addr, mem_we, mem_wdata, booted
    );

    // Requester / memory side.
    modport master (
        output fetch_req, fetch_addr, load_req, load_addr, load_data,
               load_done, reload, mem_rdata,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_err,
               load_ready, load_err, mem_addr, mem_we, mem_wdata, booted
    );
endinterface

// File: rtl/imem_addr_check.sv
// Byte address to word index conversion with misalignment / range error flag.
module imem_addr_check
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic [31:0]       byte_addr,
    output logic [ADDR_W-1:0] word_idx,
    output logic              err
);
    assign word_idx = byte_addr[ADDR_W+1:2];
    assign err      = addr_bad(byte_addr, ADDR_W);
endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares the single-port instruction memory between fetch and the program loader (BOOT/RUN/DRAIN).
// Optional statistics counters are built when IMEM_ARB_STATS_EN is defined.
module imem_fetch_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IMEM_ARB_STATS_EN
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_load_cnt,
    output logic [31:0] stat_conflict_cnt,
`endif
    imem_fetch_arbiter_if.slave bus
);

    arb_state_e        state_q;
    grant_e            last_grant_q;
    logic              rd_pend_q;
    logic              rd_err_q;
    logic [ADDR_W-1:0] addr_q;

    logic [ADDR_W-1:0] fetch_word_c;
    logic [ADDR_W-1:0] load_word_c;
    logic              fetch_bad_c;
    logic              load_bad_c;
    logic              fetch_ready_c;
    logic              load_ready_c;
    logic              fetch_xfer_c;
    logic              load_xfer_c;
    logic              fetch_rd_c;
    logic              load_wr_c;
    logic [ADDR_W-1:0] mem_addr_c;

    imem_addr_check #(.ADDR_W(ADDR_W)) u_fetch_chk (
        .byte_addr (bus.fetch_addr),
        .word_idx  (fetch_word_c),
        .err       (fetch_bad_c)
    );

    imem_addr_check #(.ADDR_W(ADDR_W)) u_load_chk (
        .byte_addr (bus.load_addr),
        .word_idx  (load_word_c),
        .err       (load_bad_c)
    );

    // Grants: loader owns BOOT, round-robin on conflict in RUN, nothing in DRAIN.
    always_comb begin
        fetch_ready_c = 1'b0;
        load_ready_c  = 1'b0;
        case (state_q)
            BOOT: load_ready_c = 1'b1;
            RUN: begin
                if (bus.fetch_req && bus.load_req) begin
                    fetch_ready_c = (last_grant_q == LOAD);
                    load_ready_c  = (last_grant_q == FETCH);
                end else begin
                    fetch_ready_c = bus.fetch_req;
                    load_ready_c  = bus.load_req;
                end
            end
            default: ;
        endcase
    end

    assign fetch_xfer_c = bus.fetch_req && fetch_ready_c;
    assign load_xfer_c  = bus.load_req && load_ready_c;
    assign fetch_rd_c   = fetch_xfer_c && !fetch_bad_c;
    assign load_wr_c    = load_xfer_c && !load_bad_c;

    // Memory address follows the granted access, otherwise holds.
    always_comb begin
        mem_addr_c = addr_q;
        if (fetch_rd_c) begin
            mem_addr_c = fetch_word_c;
        end else if (load_wr_c) begin
            mem_addr_c = load_word_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            last_grant_q <= LOAD;
            rd_pend_q    <= 1'b0;
            rd_err_q     <= 1'b0;
            addr_q       <= '0;
        end else begin
            case (state_q)
                BOOT:    if (bus.load_done) state_q <= RUN;
                RUN:     if (bus.reload) state_q <= DRAIN;
                // Any read granted in the last RUN cycle returns during DRAIN.
                DRAIN:   state_q <= BOOT;
                default: state_q <= BOOT;
            endcase
            if (fetch_xfer_c) begin
                last_grant_q <= FETCH;
            end else if (load_xfer_c) begin
                last_grant_q <= LOAD;
            end
            rd_pend_q <= fetch_xfer_c;
            rd_err_q  <= fetch_xfer_c && fetch_bad_c;
            addr_q    <= mem_addr_c;
        end
    end

    assign bus.fetch_ready = fetch_ready_c;
    assign bus.load_ready  = load_ready_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_we      = load_wr_c;
    assign bus.mem_wdata   = load_wr_c ? bus.load_data : '0;
    assign bus.load_err    = load_xfer_c && load_bad_c;
    assign bus.fetch_valid = rd_pend_q;
    assign bus.fetch_err   = rd_pend_q && rd_err_q;
    assign bus.fetch_instr = (rd_pend_q && !rd_err_q) ? bus.mem_rdata : DATA_W'(NOP_INSTR);
    assign bus.booted      = (state_q == RUN);

`ifdef IMEM_ARB_STATS_EN
    logic boot_entry_c;
    logic conflict_c;

    // DRAIN always exits to BOOT, so it marks the boot-entry edge.
    assign boot_entry_c = (state_q == DRAIN);
    assign conflict_c   = (state_q == RUN) && bus.fetch_req && bus.load_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetch_cnt    <= '0;
            stat_load_cnt     <= '0;
            stat_conflict_cnt <= '0;
        end else if (boot_entry_c) begin
            stat_fetch_cnt    <= '0;
            stat_load_cnt     <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (fetch_xfer_c && (stat_fetch_cnt != '1)) begin
                stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
            end
            if (load_xfer_c && (stat_load_cnt != '1)) begin
                stat_load_cnt <= stat_load_cnt + 32'd1;
            end
            if (conflict_c && (stat_conflict_cnt != '1)) begin
                stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
Controller that shares the single-port 1024x32 instruction memory between the CPU fetch stage and the program loader.
- Sequences the boot phase, in which only the loader writes the program, then the run phase, in which fetch reads and loader writes are arbitrated round-robin.
- Handles re-entry to boot, aligns and range-checks byte addresses, and returns read data one cycle after grant.
- Sits between the fetch stage / loader and the memory array.

Parameters:
ADDR_W, 10, word-index width; depth = 2**ADDR_W words
DATA_W, 32, instruction/data word width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_req  input  1  fetch read request
fetch_addr  input  32  byte address of requested instruction
fetch_ready  output  1  grant; transfer occurs when fetch_req & fetch_ready
fetch_valid  output  1  response strobe, one cycle after transfer
fetch_instr  output  DATA_W  instruction returned with fetch_valid
fetch_err  output  1  with fetch_valid: misaligned or out-of-range address
load_req  input  1  loader write request
load_addr  input  32  byte address of write
load_data  input  DATA_W  write data
load_ready  output  1  grant; write occurs when load_req & load_ready
load_err  output  1  one-cycle pulse: accepted write dropped (misaligned or out of range)
load_done  input  1  pulse: program loaded, enter run phase
reload  input  1  pulse: return to boot phase
mem_addr  output  ADDR_W  word index to memory
mem_we  output  1  memory write enable
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, registered (valid the cycle after the address)
booted  output  1  high while in RUN

Behaviour:
- Clock is clk; reset is reset, asynchronous and active-high.
- Reset values:
  - State BOOT; last_grant = LOAD.
  - fetch_valid, fetch_err, load_err, mem_we and booted are 0.
  - fetch_instr, mem_addr and mem_wdata are 0.
- States:
  - BOOT: load_ready = 1, fetch_ready = 0. load_done moves to RUN next cycle; a write accepted in the same cycle still completes.
  - RUN: arbitration as below. reload moves to DRAIN; a grant issued in that cycle completes.
  - DRAIN: no grants. Moves to BOOT once no read is outstanding (at most 1 cycle).
- Arbitration in RUN:
  - Grants are combinational from req and state.
  - A single requester is granted.
  - If both request, the requester not equal to last_grant wins; last_grant updates on every transfer.
  - Only one memory access occurs per cycle.
- Address check:
  - Word index = addr[ADDR_W+1:2].
  - Error if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
- Fetch with an error: the transfer is still accepted and no memory read is issued. The next cycle gives fetch_valid = 1, fetch_err = 1, fetch_instr = 0 (NOP).
- Load with an error: the transfer is accepted, mem_we stays 0, and load_err pulses in the same cycle.
- Fetch latency:
  - fetch_valid rises exactly 1 cycle after the transfer, with fetch_instr = mem_rdata.
  - Back-to-back fetches sustain 1 per cycle.
- Write: mem_we, mem_addr and mem_wdata are combinational in the transfer cycle.
- When no request is granted, mem_addr holds its last value and mem_we = 0.
- Reset mid-read: the pending response is discarded and fetch_valid = 0.
- load_done outside BOOT and reload outside RUN are ignored.

Optional Feature:
IMEM_ARB_STATS_EN
- Enabled: adds outputs stat_fetch_cnt[31:0], stat_load_cnt[31:0] and stat_conflict_cnt[31:0].
  - These count fetch transfers, load transfers, and cycles in which both requested in RUN.
  - All three saturate at 2^32-1 and clear on reset or on entry to BOOT.
- Disabled: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package imem_arb_pkg holds:
  - the state enum (BOOT, RUN, DRAIN);
  - the grant enum (FETCH, LOAD);
  - the NOP_INSTR = 32'h0 constant;
  - the address-check function.
- One sub-module, imem_addr_check: combinational byte-to-word conversion plus error flag, instantiated twice (fetch and load).

Test Plan:
- Boot write: reset, then write load_addr=0x0 with data 0x0000_03E8, then pulse load_done. Expect mem_we high for that cycle with mem_addr=0, and booted=1 the next cycle.
- Fetch in BOOT: fetch_req in BOOT. Expect fetch_ready=0 and no mem access.
- Fetch read: in RUN with mem word 5 = 0xDEADBEEF, fetch 0x14. Expect fetch_valid next cycle with 0xDEADBEEF and fetch_err=0.
- Round-robin: hold fetch_req and load_req for 4 cycles in RUN. Expect grants alternating F,L,F,L, since last_grant=LOAD after boot.
- Bad addresses: fetch 0x2 gives fetch_err=1 and instr 0 next cycle. load_addr 0x1000 gives load_err pulse and mem_we=0.
- Reload: reload in the same cycle as a fetch grant. Expect that response delivered, then DRAIN, then BOOT, booted=0. Also assert reset mid-read and check fetch_valid stays 0.
